decoder_layer_serial: RTL
=========================

DECODER_LAYER_SERIAL -- requirements
Module: decoder_layer_serial

Interface
REQ-001 SHALL have parameter IN_NUM, default 16: latent inputs, equal to the encoder output count.
REQ-002 SHALL have parameter NODE_NUM, default 32: output nodes.
REQ-003 SHALL have parameters IN_WIDTH=8 / IN_FRACTION=5: latent fixed-point format.
REQ-004 SHALL have parameters W_WIDTH=8 / W_FRACTION=6: weight and bias format.
REQ-005 SHALL have parameters OUTPUT_WIDTH=8 / OUTPUT_FRACTION=6: output format.
REQ-006 SHALL use one clock and a synchronous, active-low reset, with ports as follows.
- clk  input  1: the single clock; all state updates on the rising edge.
- rst_n  input  1: synchronous, active-low reset.
- valid  input  1: start strobe, sampled only in IDLE or DONE.
- x  input  IN_WIDTH*IN_NUM: packed latents; element k is x[k*IN_WIDTH +: IN_WIDTH], signed.
- w_rd  output  1: weight-memory read enable.
- w_addr  output  clog2(NODE_NUM*(IN_NUM+1)): weight-memory word address.
- w_data  input  W_WIDTH: signed weight word, valid one cycle after w_rd.
- out  output  OUTPUT_WIDTH*NODE_NUM: packed signed node outputs; node n is out[n*OUTPUT_WIDTH +: OUTPUT_WIDTH].
- out_ready  output  1: results complete.
- busy  output  1: computation in progress.

Function
REQ-007 SHALL run the FSM states IDLE -> MAC -> DONE, with DONE -> MAC on valid and MAC -> DONE after the last node is written.
REQ-008 SHALL, on valid high in IDLE/DONE, capture x in an internal register, clear out_ready, set busy and enter MAC on the same edge.
REQ-009 SHALL stream w_addr = n*(IN_NUM+1)+k with w_rd=1, for n = 0..NODE_NUM-1 and k = 0..IN_NUM, one address per cycle starting the cycle after acceptance, with no gaps.
REQ-010 SHALL treat word k<IN_NUM as the weight for x[k]; word k=IN_NUM is the node bias, shifted left by IN_FRACTION before it is added.
REQ-011 SHALL accumulate signed products in full precision.
- Accumulator width: IN_WIDTH + W_WIDTH + clog2(IN_NUM+1).
- Accumulator cleared at each node start; no overflow is possible.
REQ-012 SHALL requantize each node sum.
- Arithmetic right shift by IN_FRACTION + W_FRACTION - OUTPUT_FRACTION (floor).
- Then apply the activation of REQ-020.
- Then saturate to OUTPUT_WIDTH.
REQ-013 SHALL write node n's result into out on the edge its bias product is accumulated; nodes not yet recomputed hold their previous values.
REQ-014 SHALL raise out_ready and drop busy exactly NODE_NUM*(IN_NUM+1)+2 edges after the accepting edge (546 at defaults).
REQ-015 SHALL hold out_ready high in DONE until the next valid is accepted.
REQ-016 SHALL ignore valid while busy, with no restart and no change to the captured x.
REQ-017 SHALL hold w_rd=0 outside MAC; w_addr is don't-care when w_rd=0.
REQ-018 SHALL be unaffected by changes to x after acceptance.

Reset
REQ-019 SHALL, with rst_n low at a clock edge, force all of the following regardless of state, including mid-MAC:
- state IDLE;
- out = 0, out_ready = 0, busy = 0, w_rd = 0, w_addr = 0;
- accumulator and counters cleared.
- The first valid after reset SHALL start a full computation with the latency of REQ-014.

Configuration
REQ-020 SHALL support macro DECODER_RELU_EN.
- Defined: ReLU; negative shifted sums give 0 and positives saturate to 2^(OUTPUT_WIDTH-1)-1.
- Undefined: linear; signed saturation to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
- No interface or latency difference between the two builds.

Verification
REQ-021 Single-weight case: x[0]=8'h20 (1.0), other x=0, every node weight k=0 = 8'h10, other weights and biases 0 -> every out node 8'h10, with out_ready at edge 546.
REQ-022 Saturation case: all x=8'h20, all weights 8'h40, bias 0 (sum 16.0) -> every node 8'h7F.
REQ-023 Negative case: x[0]=8'h20, weight k=0 = 8'hC0, others 0 -> 8'h00 with DECODER_RELU_EN, 8'hC0 without; bias 8'h40 alone with x=0 -> 8'h40.
REQ-024 Valid while busy: second valid pulse at edge 100 after start -> no restart; out_ready still at edge 546; results from the first x.
REQ-025 Reset mid-run: rst_n low for one cycle at edge 200 -> next edge shows out=0, out_ready=0, busy=0, w_rd=0; a new valid gives correct results 546 edges later.
REQ-026 Back-to-back runs: valid in DONE with new x -> out_ready drops next edge and the address sequence restarts at w_addr=0.

Source files
------------

// File: rtl/decoder_layer_serial.sv
// Serial fully-connected decoder layer: one weight word per cycle, one MAC, per-node requantize.
// Optional DECODER_RELU_EN selects ReLU activation; otherwise linear with signed saturation.
module decoder_layer_serial #(
  parameter int IN_NUM          = 16,
  parameter int NODE_NUM        = 32,
  parameter int IN_WIDTH        = 8,
  parameter int IN_FRACTION     = 5,
  parameter int W_WIDTH         = 8,
  parameter int W_FRACTION      = 6,
  parameter int OUTPUT_WIDTH    = 8,
  parameter int OUTPUT_FRACTION = 6
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       valid,
  input  logic [IN_WIDTH*IN_NUM-1:0]                 x,
  output logic                                       w_rd,
  output logic [$clog2(NODE_NUM*(IN_NUM+1))-1:0]     w_addr,
  input  logic signed [W_WIDTH-1:0]                  w_data,
  output logic [OUTPUT_WIDTH*NODE_NUM-1:0]           out,
  output logic                                       out_ready,
  output logic                                       busy
);
  localparam int WORDS = NODE_NUM*(IN_NUM+1);
  localparam int AW    = $clog2(WORDS);
  localparam int KW    = $clog2(IN_NUM+1);
  localparam int NW    = $clog2(NODE_NUM+1);
  localparam int PW    = IN_WIDTH+W_WIDTH;
  localparam int ACC_W = IN_WIDTH+W_WIDTH+$clog2(IN_NUM+1);
  localparam int SH    = IN_FRACTION+W_FRACTION-OUTPUT_FRACTION;
  localparam logic [AW-1:0] A_LAST = AW'(WORDS-1);
  localparam logic [KW-1:0] K_LAST = KW'(IN_NUM);
  localparam logic [NW-1:0] N_LAST = NW'(NODE_NUM-1);
  localparam logic signed [ACC_W-1:0] OMAX = ACC_W'((1 << (OUTPUT_WIDTH-1)) - 1);
  localparam logic signed [ACC_W-1:0] OMIN = ACC_W'(-(1 << (OUTPUT_WIDTH-1)));

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t                           state_q;
  logic [IN_WIDTH*IN_NUM-1:0]       x_q;
  logic                             rd_q, dv_q, fin_q, rdy_q, busy_q;
  logic [AW-1:0]                    addr_q;
  logic [KW-1:0]                    k_q;
  logic [NW-1:0]                    n_q;
  logic signed [ACC_W-1:0]          acc_q;
  logic [OUTPUT_WIDTH*NODE_NUM-1:0] out_q;

  logic signed [IN_WIDTH-1:0]     x_el;
  logic signed [PW-1:0]           prod;
  logic signed [ACC_W-1:0]        prod_x, bias_x, sum_d, sh_d;
  logic [OUTPUT_WIDTH-1:0]        res_d;

  // sum_d/res_d are only consumed on the bias word, where w_data is the bias
  always_comb begin
    x_el   = x_q[k_q*IN_WIDTH +: IN_WIDTH];
    prod   = x_el * w_data;
    prod_x = {{(ACC_W-PW){prod[PW-1]}}, prod};
    bias_x = {{(ACC_W-W_WIDTH){w_data[W_WIDTH-1]}}, w_data} <<< IN_FRACTION;
    sum_d  = acc_q + bias_x;
    sh_d   = sum_d >>> SH;
    res_d  = sh_d[OUTPUT_WIDTH-1:0];
`ifdef DECODER_RELU_EN
    if (sh_d[ACC_W-1])   res_d = '0;
    else if (sh_d > OMAX) res_d = OMAX[OUTPUT_WIDTH-1:0];
`else
    if (sh_d > OMAX)      res_d = OMAX[OUTPUT_WIDTH-1:0];
    else if (sh_d < OMIN) res_d = OMIN[OUTPUT_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      rd_q    <= 1'b0;
      dv_q    <= 1'b0;
      fin_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      k_q     <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (valid) begin
            x_q     <= x;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            rd_q    <= 1'b1;
            addr_q  <= '0;
            dv_q    <= 1'b0;
            fin_q   <= 1'b0;
            k_q     <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          // dv_q marks the cycle the word requested last cycle is on w_data
          dv_q <= rd_q;
          if (rd_q) begin
            if (addr_q == A_LAST) rd_q <= 1'b0;
            else                  addr_q <= addr_q + 1'b1;
          end
          if (dv_q) begin
            if (k_q == K_LAST) begin
              out_q[n_q*OUTPUT_WIDTH +: OUTPUT_WIDTH] <= res_d;
              acc_q <= '0;
              k_q   <= '0;
              n_q   <= n_q + 1'b1;
              fin_q <= (n_q == N_LAST);
            end else begin
              acc_q <= acc_q + prod_x;
              k_q   <= k_q + 1'b1;
            end
          end
          if (fin_q) begin
            state_q <= S_DONE;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign w_rd      = rd_q;
  assign w_addr    = addr_q;
  assign out       = out_q;
  assign out_ready = rdy_q;
  assign busy      = busy_q;
endmodule
